morse_player: RTL and testbench

MORSE_PLAYER -- requirements
Module: morse_player

---
 rtl/morse_player.sv | 170 +++++++++++++++++
 tb/tb_morse_player.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_player.sv
// morse_player: drains an ASCII ring buffer and keys each character out as
// ITU Morse on led, one time unit = UNIT_CYCLES clk_24 cycles.
// Optional build macro MORSE_PUNCT_EN adds . , ? / = to the code table.
module morse_player #(
  parameter int UNIT_CYCLES = 2400000,
  parameter int READ_WAIT   = 3
) (
  input  logic        clk_24,
  input  logic        rst,
  input  logic        rx,
  input  logic [10:0] write_index,
  input  logic [6:0]  ascii_in,
  output logic [10:0] read_index,
  output logic        led,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LOOKUP, MARK, GAP} state_t;

  state_t      state;
  logic [23:0] tcnt;   // cycle within the current unit
  logic [2:0]  ucnt;   // units left in the current phase
  logic [15:0] wcnt;   // quiet cycles seen in FETCH
  logic [2:0]  ecnt;   // elements not yet finished
  logic [5:0]  pat;    // remaining elements, next one in bit 5 (1 = dash)
  logic [6:0]  chr;    // latched character

  logic [8:0]  lk;
  logic [5:0]  lk_pat;
  logic        unit_tick;

  // {element count, pattern right-aligned}; count 0 means unsupported
  function automatic logic [8:0] morse_code(input logic [6:0] c);
    logic [6:0] u;
    u = c;
    if (c >= 7'h61 && c <= 7'h7A) u = c - 7'h20;
    case (u)
      7'h41: return {3'd2, 6'b01};     7'h42: return {3'd4, 6'b1000};
      7'h43: return {3'd4, 6'b1010};   7'h44: return {3'd3, 6'b100};
      7'h45: return {3'd1, 6'b0};      7'h46: return {3'd4, 6'b0010};
      7'h47: return {3'd3, 6'b110};    7'h48: return {3'd4, 6'b0000};
      7'h49: return {3'd2, 6'b00};     7'h4A: return {3'd4, 6'b0111};
      7'h4B: return {3'd3, 6'b101};    7'h4C: return {3'd4, 6'b0100};
      7'h4D: return {3'd2, 6'b11};     7'h4E: return {3'd2, 6'b10};
      7'h4F: return {3'd3, 6'b111};    7'h50: return {3'd4, 6'b0110};
      7'h51: return {3'd4, 6'b1101};   7'h52: return {3'd3, 6'b010};
      7'h53: return {3'd3, 6'b000};    7'h54: return {3'd1, 6'b1};
      7'h55: return {3'd3, 6'b001};    7'h56: return {3'd4, 6'b0001};
      7'h57: return {3'd3, 6'b011};    7'h58: return {3'd4, 6'b1001};
      7'h59: return {3'd4, 6'b1011};   7'h5A: return {3'd4, 6'b1100};
      7'h30: return {3'd5, 6'b11111};  7'h31: return {3'd5, 6'b01111};
      7'h32: return {3'd5, 6'b00111};  7'h33: return {3'd5, 6'b00011};
      7'h34: return {3'd5, 6'b00001};  7'h35: return {3'd5, 6'b00000};
      7'h36: return {3'd5, 6'b10000};  7'h37: return {3'd5, 6'b11000};
      7'h38: return {3'd5, 6'b11100};  7'h39: return {3'd5, 6'b11110};
`ifdef MORSE_PUNCT_EN
      7'h2E: return {3'd6, 6'b010101}; 7'h2C: return {3'd6, 6'b110011};
      7'h3F: return {3'd6, 6'b001100}; 7'h2F: return {3'd5, 6'b10010};
      7'h3D: return {3'd5, 6'b10001};
`endif
      default: return 9'd0;
    endcase
  endfunction

  // table lookup on the latched char, pattern left-aligned so bit 5 plays first
  always_comb begin
    lk     = morse_code(chr);
    lk_pat = lk[5:0] << (3'd6 - lk[8:6]);
  end

  assign unit_tick = (tcnt == 24'(UNIT_CYCLES - 1));

  // player state machine: fetch, decode, then alternate mark/gap phases
  always_ff @(posedge clk_24) begin
    if (rst) begin
      state      <= IDLE;
      read_index <= '0;
      led        <= 1'b0;
      busy       <= 1'b0;
      tcnt       <= '0;
      ucnt       <= '0;
      wcnt       <= '0;
      ecnt       <= '0;
      pat        <= '0;
      chr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_index != write_index) begin
            state <= FETCH;
            busy  <= 1'b1;
            wcnt  <= '0;
          end
        end
        FETCH: begin
          // a write cycle disturbs the buffer output, so restart the settle count
          if (rx) begin
            wcnt <= '0;
          end else if (wcnt == 16'(READ_WAIT)) begin
            chr        <= ascii_in;
            read_index <= read_index + 11'd1;
            wcnt       <= '0;
            state      <= LOOKUP;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        LOOKUP: begin
          tcnt <= '0;
          if (chr == 7'h20) begin
            // word space: 4 more units on top of the previous character gap
            state <= GAP;
            ucnt  <= 3'd4;
            ecnt  <= '0;
          end else if (lk[8:6] != 3'd0) begin
            state <= MARK;
            led   <= 1'b1;
            ecnt  <= lk[8:6];
            pat   <= lk_pat;
            ucnt  <= lk_pat[5] ? 3'd3 : 3'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MARK: begin
          if (unit_tick) begin
            tcnt <= '0;
            if (ucnt == 3'd1) begin
              led   <= 1'b0;
              state <= GAP;
              ecnt  <= ecnt - 3'd1;
              pat   <= pat << 1;
              ucnt  <= (ecnt > 3'd1) ? 3'd1 : 3'd3;
            end else begin
              ucnt <= ucnt - 3'd1;
            end
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        GAP: begin
          if (unit_tick) begin
            tcnt <= '0;
            if (ucnt == 3'd1) begin
              if (ecnt != 3'd0) begin
                state <= MARK;
                led   <= 1'b1;
                ucnt  <= pat[5] ? 3'd3 : 3'd1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              ucnt <= ucnt - 3'd1;
            end
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// tb_morse_player: drives characters through a model ring buffer and checks
// the led/busy timelines against a Morse-string timing model.
module tb_morse_player;
  localparam int U  = 4;
  localparam int RW = 3;

  logic        clk_24 = 1'b0;
  logic        rst, rx;
  logic [10:0] write_index, read_index;
  logic [6:0]  ascii_in;
  logic        led, busy;
  logic [6:0]  mem [0:2047];
  logic [10:0] rd_m;
  int          tests = 0;
  int          fails = 0;

  assign ascii_in = mem[read_index];

  always #5 clk_24 = ~clk_24;

  morse_player #(.UNIT_CYCLES(U), .READ_WAIT(RW)) dut (
    .clk_24(clk_24), .rst(rst), .rx(rx), .write_index(write_index),
    .ascii_in(ascii_in), .read_index(read_index), .led(led), .busy(busy)
  );

  // dots and dashes for a character; " " = word space, "" = skipped
  function automatic string morse_of(input logic [6:0] c);
    logic [6:0] u;
    u = c;
    if (c >= 7'h61 && c <= 7'h7A) u = c - 7'h20;
    case (u)
      7'h41: return ".-";    7'h42: return "-...";  7'h43: return "-.-.";
      7'h44: return "-..";   7'h45: return ".";     7'h46: return "..-.";
      7'h47: return "--.";   7'h48: return "....";  7'h49: return "..";
      7'h4A: return ".---";  7'h4B: return "-.-";   7'h4C: return ".-..";
      7'h4D: return "--";    7'h4E: return "-.";    7'h4F: return "---";
      7'h50: return ".--.";  7'h51: return "--.-";  7'h52: return ".-.";
      7'h53: return "...";   7'h54: return "-";     7'h55: return "..-";
      7'h56: return "...-";  7'h57: return ".--";   7'h58: return "-..-";
      7'h59: return "-.--";  7'h5A: return "--..";
      7'h30: return "-----"; 7'h31: return ".----"; 7'h32: return "..---";
      7'h33: return "...--"; 7'h34: return "....-"; 7'h35: return ".....";
      7'h36: return "-...."; 7'h37: return "--..."; 7'h38: return "---..";
      7'h39: return "----.";
      7'h20: return " ";
`ifdef MORSE_PUNCT_EN
      7'h2E: return ".-.-.-"; 7'h2C: return "--..--"; 7'h3F: return "..--..";
      7'h2F: return "-..-.";  7'h3D: return "-...-";
`endif
      default: return "";
    endcase
  endfunction

  // Queue one char at rd_m, apply rx per cycle of FETCH (bit j = cycle j after
  // FETCH entry), and compare led/busy over the whole expected timeline.
  task automatic run_char(input logic [6:0] ch, input logic [31:0] rxmask, input string name);
    string m;
    int    c, run, t, end_t, ncyc, len, bad_l, bad_b;
    logic  e [0:1023];
    logic  got_l, got_b;
    logic [10:0] exp_rd;
    m = morse_of(ch);
    for (int j = 0; j < 1024; j++) e[j] = 1'b0;
    // latch happens at the end of the first run of RW+1 consecutive quiet cycles
    c = -1; run = 0;
    for (int j = 0; j < 64 && c < 0; j++) begin
      if (j < 32 && rxmask[j]) run = 0; else run = run + 1;
      if (run == RW + 1) c = j;
    end
    t = c + 2;
    if (m == " ") end_t = t + 4 * U;
    else if (m.len() == 0) end_t = c + 2;
    else begin
      for (int k = 0; k < m.len(); k++) begin
        len = (m[k] == 8'h2D) ? 3 : 1;
        for (int q = 0; q < len * U; q++) e[t + q] = 1'b1;
        t = t + len * U;
        t = t + ((k == m.len() - 1) ? 3 : 1) * U;
      end
      end_t = t;
    end
    ncyc = end_t + 2;
    bad_l = -1; bad_b = -1; got_l = 1'b0; got_b = 1'b0;
    @(negedge clk_24);
    mem[rd_m] = ch;
    write_index = rd_m + 11'd1;
    rx = 1'b0;
    @(posedge clk_24);
    for (int j = 0; j < ncyc; j++) begin
      #1 rx = (j < 32) ? rxmask[j] : 1'b0;
      @(negedge clk_24);
      if (bad_l < 0 && led !== e[j]) begin bad_l = j; got_l = led; end
      if (bad_b < 0 && busy !== (j < end_t)) begin bad_b = j; got_b = busy; end
      @(posedge clk_24);
    end
    rx = 1'b0;
    exp_rd = rd_m + 11'd1;
    tests++;
    if (bad_l >= 0) begin
      fails++;
      $display("FAIL %s led: cycle %0d got %b expected %b", name, bad_l, got_l, e[bad_l]);
    end
    tests++;
    if (bad_b >= 0) begin
      fails++;
      $display("FAIL %s busy: cycle %0d got %b expected %b", name, bad_b, got_b, bad_b < end_t);
    end
    tests++;
    if (read_index !== exp_rd) begin
      fails++;
      $display("FAIL %s read_index: got %0d expected %0d", name, read_index, exp_rd);
    end
    rd_m = exp_rd;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b0; write_index = '0;
    repeat (3) @(posedge clk_24);
    #1 rst = 1'b0;
    @(negedge clk_24);
    tests++;
    if (led !== 1'b0 || busy !== 1'b0 || read_index !== 11'd0) begin
      fails++;
      $display("FAIL reset: led=%b busy=%b rd=%0d expected 0 0 0", led, busy, read_index);
    end
    rd_m = '0;
  endtask

  task automatic test_letters();
    run_char(7'h45, 32'd0, "E");
    run_char(7'h41, 32'd0, "A");
    run_char(7'h61, 32'd0, "a");
    run_char(7'h54, 32'd0, "T");
    run_char(7'h30, 32'd0, "zero");
    run_char(7'h20, 32'd0, "space");
    run_char(7'h23, 32'd0, "unsupported");
  endtask

  task automatic test_rx_stall();
    run_char(7'h4B, 32'b110, "rx_stall");
    run_char(7'h4E, 32'b1001, "rx_stall2");
  endtask

  task automatic test_punct();
    run_char(7'h3F, 32'd0, "question");
    run_char(7'h2F, 32'd0, "slash");
  endtask

  task automatic test_random();
    logic [6:0]  ch;
    logic [31:0] msk;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: ch = 7'h41 + 7'($urandom_range(0, 25));
        1: ch = 7'h30 + 7'($urandom_range(0, 9));
        default: ch = 7'($urandom_range(0, 127));
      endcase
      msk = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h3F) : 32'd0;
      run_char(ch, msk, "random");
    end
  endtask

  task automatic test_reset_mid_mark();
    int seen, lit;
    @(negedge clk_24);
    mem[rd_m] = 7'h4F;
    write_index = rd_m + 11'd1;
    seen = 0;
    for (int j = 0; j < 40 && seen == 0; j++) begin
      @(negedge clk_24);
      if (led === 1'b1) seen = 1;
    end
    tests++;
    if (seen == 0) begin
      fails++;
      $display("FAIL reset_mid_mark start: got no mark expected mark within 40 cycles");
    end
    repeat (5) @(negedge clk_24);
    rst = 1'b1; write_index = '0;
    @(posedge clk_24);
    #1 rst = 1'b0;
    @(negedge clk_24);
    tests++;
    if (led !== 1'b0 || busy !== 1'b0 || read_index !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_mark: led=%b busy=%b rd=%0d expected 0 0 0", led, busy, read_index);
    end
    lit = 0;
    repeat (30) begin
      @(negedge clk_24);
      if (led !== 1'b0 || busy !== 1'b0) lit = 1;
    end
    tests++;
    if (lit != 0) begin
      fails++;
      $display("FAIL reset_mid_mark quiet: got activity expected led=0 busy=0");
    end
    rd_m = '0;
  endtask

  task automatic test_wrap();
    int done;
    for (int i = 0; i < 2048; i++) mem[i] = 7'h01;
    @(negedge clk_24);
    write_index = 11'd2047;
    done = 0;
    for (int j = 0; j < 20000 && done == 0; j++) begin
      @(negedge clk_24);
      if (read_index == 11'd2047 && busy === 1'b0) done = 1;
    end
    tests++;
    if (done == 0) begin
      fails++;
      $display("FAIL wrap skip: rd=%0d busy=%b expected 2047 0", read_index, busy);
    end
    rd_m = 11'd2047;
    run_char(7'h54, 32'd0, "wrap_T");
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 7'h01;
    rst = 1'b1; rx = 1'b0; write_index = '0;
    test_reset();
    test_letters();
    test_rx_stall();
    test_punct();
    test_random();
    test_reset_mid_mark();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
